cdb_rr_arbiter: RTL and testbench
=================================

Name: cdb_rr_arbiter

Overview:
- Arbitrates one Common Data Bus broadcast slot per cycle among NUM_REQ completing functional units.
- Two request classes:
  - High-priority requests (prio=1), e.g. fixed-latency units that cannot hold a result, go ahead of low-priority ones.
  - Low-priority requests are served round-robin.
- A per-requester wait counter prevents high-priority traffic from starving low-priority requesters.
- Sits between the FU result latches and the CDB driver; the grant is combinational, and the pointer and counters are registered.

Parameters:
- NUM_REQ, 8, number of requesters (need not be a power of two).
- STARVE_LIMIT, 4, cycles a low-priority request may be denied before it is forced (≥1).

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  branch-mispredict squash; clears arbitration state
- en  in  1  CDB available this cycle; 0 = no grant, state holds
- req  in  NUM_REQ  per-unit request; held until granted
- prio  in  NUM_REQ  per-unit class; 1 = high; sampled only where req=1
- gnt  out  NUM_REQ  one-hot grant, combinational
- gnt_valid  out  1  |gnt
- gnt_idx  out  $clog2(NUM_REQ)  index of the granted requester; 0 when !gnt_valid
- ptr  out  $clog2(NUM_REQ)  current round-robin start pointer, registered
- starved  out  NUM_REQ  wait[i]==STARVE_LIMIT

Behaviour:
- Reset values: ptr=0, all wait counters=0. While reset or flush is high, gnt=0, gnt_valid=0, gnt_idx=0.
- Grant selection, applied only when en=1 and not reset/flush. Exactly one grant:
  1. If any (req & starved & ~prio) is set, grant the lowest such index.
  2. Else if any (req & prio) is set, grant the first such index scanning ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1.
  3. Else if any req is set, grant the first such index in the same rotating order.
  4. Else no grant.
- Pointer update:
  - On a grant, ptr <= (gnt_idx==NUM_REQ-1) ? 0 : gnt_idx+1.
  - With no grant or en=0, ptr holds.
- Wait counters (width $clog2(STARVE_LIMIT+1)), updated per i when en=1:
  - req[i]=0, prio[i]=1, or gnt[i]=1: counter <= 0.
  - Otherwise: counter <= min(counter+1, STARVE_LIMIT), saturating.
- When en=0, all counters hold, so a stalled bus does not count as denial.
- flush (registered effect): ptr<=0 and all counters<=0 next cycle; no grant in the flush cycle. Reset has priority over flush. flush has priority over en.
- Latency: zero-cycle, same-cycle combinational request-to-grant. The state effect of a grant is visible next cycle.
- A request that drops without a grant clears its counter; this is legal, not an error.
- prio changing while a request is pending: the class is re-evaluated every cycle, and the counter clears on any cycle with prio=1.

Decomposition:
- No package types needed. STARVE_LIMIT stays a local parameter; the CDB slot count is defined in the shared defs only if it is later generalised to multi-lane.
- Natural sub-module: rr_first_pick.
  - Parameter WIDTH.
  - Inputs: vec[WIDTH] and start[$clog2(WIDTH)].
  - Outputs: one-hot pick, idx, and valid.
  - Implements a rotating first-one find with wrap for non-power-of-two WIDTH.
  - Instantiated twice: high-class vector and all-request vector.
- Lowest-index starved pick uses a plain priority encoder in the top level.

Test Plan (NUM_REQ=4, STARVE_LIMIT=3):
- Round-robin:
  - Stimulus: reset, then req=4'b1111, prio=0, en=1 for 5 cycles.
  - Required: gnt_idx 0,1,2,3,0; ptr 1,2,3,0,1.
- High priority over low:
  - Stimulus: req=4'b0011, prio=4'b0010, ptr=0.
  - Required: gnt=4'b0010; wait[0] increments to 1.
- Starvation override:
  - Stimulus: req[0]=1 with prio[0]=0, plus req[2]=1 with prio[2]=1 continuously.
  - Required: cycles 1-3 grant idx 2, with starved[0] asserting after the 3rd denial; cycle 4 grants idx 0; wait[0] then returns to 0.
- en stall:
  - Stimulus: req=4'b0101, en=0 for 4 cycles, then en=1.
  - Required: gnt=0 throughout the stall; ptr and counters unchanged; the first grant after the stall follows the pre-stall ptr.
- Flush mid-operation:
  - Stimulus: ptr=2, wait[1]=2, then pulse flush with req=4'b1111.
  - Required: gnt=0 in the flush cycle; next cycle ptr=0, starved=0, gnt_idx=0.
- Wrap and empty:
  - Stimulus: ptr=3 with req=4'b1000, then req=0.
  - Required: first cycle grants idx 3 and ptr wraps to 0; with req=0, gnt_valid=0 and ptr holds 0.

Source files
------------

// File: rtl/cdb_rr_arbiter_pkg.sv
// Shared helpers for the CDB arbiter slice.
// No types are exported. The only export is an index-width helper, which
// keeps degenerate widths at 1 bit so port declarations stay legal.
package cdb_rr_arbiter_pkg;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_rr_arbiter_rr_first_pick.sv
// Rotating first-one finder.
// Scans vec starting at index `start`, wrapping at WIDTH.
// WIDTH need not be a power of two.
//   vec   in  WIDTH  candidate vector
//   start in  IW     first index to examine (values >= WIDTH scan from 0)
//   pick  out WIDTH  one-hot selection
//   idx   out IW     index of the selection, 0 when !valid
//   valid out 1      any bit of vec set
module rr_first_pick
  import cdb_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned IW = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  input  logic [IW-1:0]    start,
  output logic [WIDTH-1:0] pick,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  int unsigned base;
  int unsigned pos;

  always_comb begin
    pick  = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    base  = 32'(start);
    if (base >= WIDTH) base = 0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      // Explicit wrap instead of a power-of-two mask, so odd widths work.
      pos = base + k;
      if (pos >= WIDTH) pos = pos - WIDTH;
      if (!valid && vec[IW'(pos)]) begin
        valid           = 1'b1;
        idx             = IW'(pos);
        pick[IW'(pos)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_rr_arbiter.sv
// Common Data Bus slot arbiter.
// One grant per cycle. Starved low-priority requesters go first, then
// high-priority requesters in round-robin order, then all requesters in
// round-robin order. The grant is combinational; the pointer and the
// wait counters are registered.
//   clock, reset   clock; synchronous active-high reset
//   flush          squash: no grant this cycle, state cleared next cycle
//   en             CDB slot available; when low, no grant and state holds
//   req, prio      per-unit request and class (1 = high)
//   gnt            one-hot grant
//   gnt_valid      |gnt
//   gnt_idx        granted index, 0 when no grant
//   ptr            round-robin start pointer
//   starved        wait counter has reached STARVE_LIMIT
module cdb_rr_arbiter
  import cdb_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 8,
  parameter int unsigned STARVE_LIMIT = 4,
  localparam int unsigned IW = idx_width(NUM_REQ),
  localparam int unsigned WW = idx_width(STARVE_LIMIT + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] prio,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IW-1:0]      gnt_idx,
  output logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] starved
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [WW-1:0] wait_q [NUM_REQ];
  logic [WW-1:0] wait_d [NUM_REQ];

  logic               active;
  logic [NUM_REQ-1:0] st_vec, st_pick;
  logic [IW-1:0]      st_idx;
  logic               st_valid;

  logic [NUM_REQ-1:0] hi_pick, any_pick;
  logic [IW-1:0]      hi_idx, any_idx;
  logic               hi_valid, any_valid;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++)
      starved[i] = (wait_q[i] == WW'(STARVE_LIMIT));
  end

  // Starvation override uses a fixed lowest-index priority encoder.
  always_comb begin
    st_vec   = req & starved & ~prio;
    st_pick  = '0;
    st_idx   = '0;
    st_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!st_valid && st_vec[i]) begin
        st_valid   = 1'b1;
        st_idx     = IW'(i);
        st_pick[i] = 1'b1;
      end
    end
  end

  rr_first_pick #(.WIDTH(NUM_REQ)) u_hi_pick (
    .vec   (req & prio),
    .start (ptr_q),
    .pick  (hi_pick),
    .idx   (hi_idx),
    .valid (hi_valid)
  );

  rr_first_pick #(.WIDTH(NUM_REQ)) u_any_pick (
    .vec   (req),
    .start (ptr_q),
    .pick  (any_pick),
    .idx   (any_idx),
    .valid (any_valid)
  );

  always_comb begin
    active  = en && !reset && !flush;
    gnt     = '0;
    gnt_idx = '0;
    if (active) begin
      if (st_valid) begin
        gnt     = st_pick;
        gnt_idx = st_idx;
      end else if (hi_valid) begin
        gnt     = hi_pick;
        gnt_idx = hi_idx;
      end else if (any_valid) begin
        gnt     = any_pick;
        gnt_idx = any_idx;
      end
    end
    gnt_valid = |gnt;
  end

  always_comb begin
    ptr_d = ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) wait_d[i] = wait_q[i];
    if (flush) begin
      ptr_d = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) wait_d[i] = '0;
    end else if (en) begin
      if (gnt_valid)
        ptr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        // High-priority cycles and dropped requests are not denials.
        if (!req[i] || prio[i] || gnt[i])
          wait_d[i] = '0;
        else if (wait_q[i] != WW'(STARVE_LIMIT))
          wait_d[i] = wait_q[i] + WW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) wait_q[i] <= wait_d[i];
    end
  end

  assign ptr = ptr_q;

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
module tb_cdb_rr_arbiter;

  localparam int N   = 4;
  localparam int LIM = 3;

  logic         clock = 1'b0;
  logic         reset, flush, en;
  logic [N-1:0] req, prio;
  logic [N-1:0] gnt, starved;
  logic         gnt_valid;
  logic [1:0]   gnt_idx, ptr;

  int errors = 0;
  int checks = 0;

  // Reference model state: round-robin start and denial counts.
  int m_ptr;
  int m_w [N];

  // Values observed at the most recent sample point.
  int obs_gnt, obs_idx, obs_valid, obs_ptr, obs_st;

  always #5 clock = ~clock;

  cdb_rr_arbiter #(.NUM_REQ(4), .STARVE_LIMIT(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .en        (en),
    .req       (req),
    .prio      (prio),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .ptr       (ptr),
    .starved   (starved)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, check every output against the model at
  // the negative edge, then advance the model across the rising edge.
  task automatic step(input logic rst, input logic fl, input logic e,
                      input logic [N-1:0] r, input logic [N-1:0] p);
    int exp_idx, exp_gnt, exp_st, j;
    bit exp_v;
    reset = rst; flush = fl; en = e; req = r; prio = p;
    @(negedge clock);
    exp_idx = 0; exp_v = 0; exp_st = 0;
    for (int k = 0; k < N; k++) if (m_w[k] == LIM) exp_st |= (1 << k);
    if (!rst && !fl && e) begin
      for (int k = 0; k < N; k++)
        if (!exp_v && r[k] && !p[k] && m_w[k] == LIM) begin exp_v = 1; exp_idx = k; end
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (!exp_v && r[j] && p[j]) begin exp_v = 1; exp_idx = j; end
      end
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (!exp_v && r[j]) begin exp_v = 1; exp_idx = j; end
      end
    end
    exp_gnt = exp_v ? (1 << exp_idx) : 0;
    obs_gnt = int'(gnt); obs_idx = int'(gnt_idx); obs_valid = int'(gnt_valid);
    obs_ptr = int'(ptr); obs_st = int'(starved);
    chk("gnt", obs_gnt, exp_gnt);
    chk("gnt_valid", obs_valid, int'(exp_v));
    chk("gnt_idx", obs_idx, exp_idx);
    chk("ptr", obs_ptr, m_ptr);
    chk("starved", obs_st, exp_st);
    @(posedge clock);
    if (rst || fl) begin
      m_ptr = 0;
      for (int k = 0; k < N; k++) m_w[k] = 0;
    end else if (e) begin
      if (exp_v) m_ptr = (exp_idx + 1) % N;
      for (int k = 0; k < N; k++) begin
        if (!r[k] || p[k] || (exp_v && exp_idx == k)) m_w[k] = 0;
        else if (m_w[k] < LIM) m_w[k] = m_w[k] + 1;
      end
    end
    #1;
  endtask

  int rr_idx [5] = '{0, 1, 2, 3, 0};
  int rr_ptr [5] = '{1, 2, 3, 0, 1};
  int sv_idx [5] = '{2, 2, 2, 0, 2};
  int sv_st  [5] = '{0, 0, 0, 1, 0};

  initial begin
    m_ptr = 0;
    for (int k = 0; k < N; k++) m_w[k] = 0;

    // Reset, then reset together with flush: reset wins, no grant.
    step(1, 0, 0, 4'b1111, 4'b0000);
    step(1, 1, 1, 4'b1111, 4'b0000);
    chk("reset_gnt", obs_gnt, 0);
    chk("reset_ptr", int'(ptr), 0);
    chk("reset_starved", int'(starved), 0);

    // Round-robin across all low-priority requesters.
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 4'b1111, 4'b0000);
      chk("rr_idx", obs_idx, rr_idx[i]);
      chk("rr_ptr", int'(ptr), rr_ptr[i]);
    end

    // High priority beats low priority from ptr=0.
    step(0, 1, 1, 4'b1111, 4'b0000);
    chk("flush_gnt", obs_gnt, 0);
    chk("flush_ptr", int'(ptr), 0);
    step(0, 0, 1, 4'b0011, 4'b0010);
    chk("hp_gnt", obs_gnt, 4'b0010);

    // Starvation override: three denials, then forced grant.
    step(0, 1, 1, 4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 4'b0101, 4'b0100);
      chk("starve_idx", obs_idx, sv_idx[i]);
      chk("starve_flag", (obs_st & 1), sv_st[i]);
    end

    // Bus stall: nothing moves, then resume from the held pointer.
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 4'b0101, 4'b0000);
      chk("stall_gnt", obs_gnt, 0);
      chk("stall_ptr", int'(ptr), 3);
    end
    step(0, 0, 1, 4'b0101, 4'b0000);
    chk("post_stall_idx", obs_idx, 0);

    // Build ptr=2 with wait[3]=2, then flush mid-operation.
    step(0, 1, 1, 4'b0000, 4'b0000);
    step(0, 0, 1, 4'b1010, 4'b0010);
    step(0, 0, 1, 4'b1010, 4'b0010);
    chk("preflush_ptr", int'(ptr), 2);
    step(0, 1, 1, 4'b1111, 4'b0000);
    chk("midflush_gnt", obs_gnt, 0);
    chk("postflush_ptr", int'(ptr), 0);
    chk("postflush_starved", int'(starved), 0);
    step(0, 0, 1, 4'b1111, 4'b0000);
    chk("postflush_idx", obs_idx, 0);

    // Pointer wrap at the top index, then an empty cycle.
    step(0, 0, 1, 4'b0100, 4'b0000);
    chk("wrap_setup_ptr", int'(ptr), 3);
    step(0, 0, 1, 4'b1000, 4'b0000);
    chk("wrap_idx", obs_idx, 3);
    chk("wrap_ptr", int'(ptr), 0);
    step(0, 0, 1, 4'b0000, 4'b0000);
    chk("empty_valid", obs_valid, 0);
    chk("empty_ptr", int'(ptr), 0);

    step(1, 0, 1, 4'b1111, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
